pipeline_control_unit: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V core. It combines the load-use hazard signal from `hazard_detection_unit` with branch redirects, instruction and data memory wait states, and the multi-cycle mul/div unit. From these it produces per-pipeline-register stall and bubble controls. It also keeps saturating stall and flush performance counters.

---
 rtl/pipeline_control_unit_pkg.sv | 24 ++
 rtl/pipeline_control_unit_if.sv | 44 ++++
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_control_unit.sv | 119 +++++++++++
 tb/tb_pipeline_control_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_control_unit_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states,
// the per-register control bundle and the default counter width.
package pipeline_control_unit_pkg;

    localparam int unsigned PCU_CNT_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        PCU_RUN         = 2'd0,
        PCU_MULDIV_WAIT = 2'd1,
        PCU_DMEM_WAIT   = 2'd2
    } pcu_state_e;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic idex_stall;
        logic exmem_stall;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } pcu_ctrl_t;

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Hazard/event inputs and stall/flush/counter outputs of the pipeline
// control unit; slave is the sequencer side, master the pipeline side.
interface pipeline_control_unit_if
    import pipeline_control_unit_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = PCU_CNT_WIDTH_DEFAULT
) ();

    logic                 LU_HAZ_SIG;
    logic                 BRANCH_TAKEN;
    logic                 IMEM_BUSY;
    logic                 DMEM_BUSY;
    logic                 MULDIV_START;
    logic                 MULDIV_DONE;

    logic                 PC_STALL;
    logic                 IFID_STALL;
    logic                 IDEX_STALL;
    logic                 EXMEM_STALL;
    logic                 IFID_FLUSH;
    logic                 IDEX_FLUSH;
    logic                 EXMEM_FLUSH;
    logic                 MEMWB_FLUSH;
    logic [CNT_WIDTH-1:0] STALL_COUNT;
    logic [CNT_WIDTH-1:0] FLUSH_COUNT;
    logic [1:0]           CTRL_STATE;

    modport master (
        output LU_HAZ_SIG, BRANCH_TAKEN, IMEM_BUSY, DMEM_BUSY,
               MULDIV_START, MULDIV_DONE,
        input  PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL,
               IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, MEMWB_FLUSH,
               STALL_COUNT, FLUSH_COUNT, CTRL_STATE
    );

    modport slave (
        input  LU_HAZ_SIG, BRANCH_TAKEN, IMEM_BUSY, DMEM_BUSY,
               MULDIV_START, MULDIV_DONE,
        output PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL,
               IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, MEMWB_FLUSH,
               STALL_COUNT, FLUSH_COUNT, CTRL_STATE
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             INC,
    output logic [WIDTH-1:0] COUNT
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            COUNT <= '0;
        end else if (INC && (COUNT != {WIDTH{1'b1}})) begin
            COUNT <= COUNT + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Central stall/flush sequencer: priority-encodes memory waits, mul/div,
// redirects and load-use hazards into per-register stall/bubble controls.
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = PCU_CNT_WIDTH_DEFAULT
) (
    input logic                   CLK,
    input logic                   RESET,
    pipeline_control_unit_if.slave bus
);

    pcu_state_e           state_q;
    pcu_state_e           state_d;
    logic                 if_flush_pending_q;
    logic                 if_flush_pending_d;
    logic                 muldiv_done_seen_q;
    logic                 muldiv_done_seen_d;
    logic                 muldiv_hold;
    logic                 flush_inc;
    pcu_ctrl_t            ctrl;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;

    // An op is in flight while EX holds it (level START, or already waiting)
    // and no completion has been observed yet.
    assign muldiv_hold = ((state_q == PCU_MULDIV_WAIT) || bus.MULDIV_START)
                         && !bus.MULDIV_DONE && !muldiv_done_seen_q;

    // Priority encoder: first matching rule drives controls and next state.
    always_comb begin
        ctrl               = '0;
        state_d            = PCU_RUN;
        if_flush_pending_d = if_flush_pending_q;
        muldiv_done_seen_d = muldiv_done_seen_q;
        flush_inc          = 1'b0;

        if (bus.DMEM_BUSY) begin
            ctrl.pc_stall      = 1'b1;
            ctrl.ifid_stall    = 1'b1;
            ctrl.idex_stall    = 1'b1;
            ctrl.exmem_stall   = 1'b1;
            ctrl.memwb_flush   = 1'b1;
            state_d            = PCU_DMEM_WAIT;
            muldiv_done_seen_d = muldiv_done_seen_q | bus.MULDIV_DONE;
        end else begin
            muldiv_done_seen_d = 1'b0;
            if (muldiv_hold) begin
                ctrl.pc_stall    = 1'b1;
                ctrl.ifid_stall  = 1'b1;
                ctrl.idex_stall  = 1'b1;
                ctrl.exmem_flush = 1'b1;
                state_d          = PCU_MULDIV_WAIT;
            end else if (bus.BRANCH_TAKEN) begin
                ctrl.ifid_flush    = 1'b1;
                ctrl.idex_flush    = 1'b1;
                flush_inc          = 1'b1;
                // A completed fetch is discarded right here; only a busy one
                // leaves a wrong-path instruction to drop later.
                if_flush_pending_d = bus.IMEM_BUSY;
            end else if (bus.LU_HAZ_SIG) begin
                ctrl.pc_stall   = 1'b1;
                ctrl.ifid_stall = 1'b1;
                ctrl.idex_flush = 1'b1;
            end else if (bus.IMEM_BUSY) begin
                ctrl.pc_stall   = 1'b1;
                ctrl.ifid_flush = 1'b1;
            end else if (if_flush_pending_q) begin
                ctrl.ifid_flush    = 1'b1;
                if_flush_pending_d = 1'b0;
            end
        end

        if (RESET) begin
            ctrl      = '0;
            flush_inc = 1'b0;
        end
    end

    // State and flag register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q            <= PCU_RUN;
            if_flush_pending_q <= 1'b0;
            muldiv_done_seen_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            if_flush_pending_q <= if_flush_pending_d;
            muldiv_done_seen_q <= muldiv_done_seen_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (ctrl.pc_stall),
        .COUNT (stall_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (flush_inc),
        .COUNT (flush_count)
    );

    assign bus.PC_STALL    = ctrl.pc_stall;
    assign bus.IFID_STALL  = ctrl.ifid_stall;
    assign bus.IDEX_STALL  = ctrl.idex_stall;
    assign bus.EXMEM_STALL = ctrl.exmem_stall;
    assign bus.IFID_FLUSH  = ctrl.ifid_flush;
    assign bus.IDEX_FLUSH  = ctrl.idex_flush;
    assign bus.EXMEM_FLUSH = ctrl.exmem_flush;
    assign bus.MEMWB_FLUSH = ctrl.memwb_flush;
    assign bus.STALL_COUNT = stall_count;
    assign bus.FLUSH_COUNT = flush_count;
    assign bus.CTRL_STATE  = 2'(state_q);

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed-vector bench for pipeline_control_unit: the driver queues the
// hand-computed response for each cycle, a negedge monitor compares it.
module tb_pipeline_control_unit;

    localparam int unsigned CW = 4;

    // Input vector bits: {reset, lu, branch, imem, dmem, start, done}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_RST  = 7'b1000000;
    localparam logic [6:0] I_LU   = 7'b0100000;
    localparam logic [6:0] I_BR   = 7'b0010000;
    localparam logic [6:0] I_IB   = 7'b0001000;
    localparam logic [6:0] I_DB   = 7'b0000100;
    localparam logic [6:0] I_MS   = 7'b0000010;
    localparam logic [6:0] I_MD   = 7'b0000001;

    // Control vector: {PC,IFID,IDEX,EXMEM stall, IFID,IDEX,EXMEM,MEMWB flush}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_DM   = 8'b1111_0001;
    localparam logic [7:0] C_MD   = 8'b1110_0010;
    localparam logic [7:0] C_BR   = 8'b0000_1100;
    localparam logic [7:0] C_LU   = 8'b1100_0100;
    localparam logic [7:0] C_IW   = 8'b1000_1000;
    localparam logic [7:0] C_PF   = 8'b0000_1000;

    typedef struct {
        int           id;
        logic [7:0]   ctrl;
        logic [1:0]   st;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   step_id = 0;

    pipeline_control_unit_if #(.CNT_WIDTH(CW)) bus ();

    pipeline_control_unit #(.CNT_WIDTH(CW)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [6:0] in, input logic [7:0] c,
                        input logic [1:0] s, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        reset            = in[6];
        bus.LU_HAZ_SIG   = in[5];
        bus.BRANCH_TAKEN = in[4];
        bus.IMEM_BUSY    = in[3];
        bus.DMEM_BUSY    = in[2];
        bus.MULDIV_START = in[1];
        bus.MULDIV_DONE  = in[0];
        step_id++;
        e.id   = step_id;
        e.ctrl = c;
        e.st   = s;
        e.sc   = CW'(sc);
        e.fc   = CW'(fc);
        sb.push_back(e);
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [7:0] got;
            e   = sb.pop_front();
            got = {bus.PC_STALL, bus.IFID_STALL, bus.IDEX_STALL, bus.EXMEM_STALL,
                   bus.IFID_FLUSH, bus.IDEX_FLUSH, bus.EXMEM_FLUSH, bus.MEMWB_FLUSH};
            checks++;
            if (got !== e.ctrl) begin
                fails++;
                $display("FAIL ctrl step %0d: got %b want %b", e.id, got, e.ctrl);
            end
            checks++;
            if (bus.CTRL_STATE !== e.st) begin
                fails++;
                $display("FAIL state step %0d: got %0d want %0d", e.id, bus.CTRL_STATE, e.st);
            end
            checks++;
            if (bus.STALL_COUNT !== e.sc) begin
                fails++;
                $display("FAIL stall_count step %0d: got %0d want %0d", e.id, bus.STALL_COUNT, e.sc);
            end
            checks++;
            if (bus.FLUSH_COUNT !== e.fc) begin
                fails++;
                $display("FAIL flush_count step %0d: got %0d want %0d", e.id, bus.FLUSH_COUNT, e.fc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        bus.LU_HAZ_SIG   = 1'b0;
        bus.BRANCH_TAKEN = 1'b0;
        bus.IMEM_BUSY    = 1'b0;
        bus.DMEM_BUSY    = 1'b0;
        bus.MULDIV_START = 1'b0;
        bus.MULDIV_DONE  = 1'b0;
        repeat (2) @(posedge clk);

        // Reset forces controls low even with events present
        step(I_RST | I_DB | I_LU, C_NONE, 2'd0, 0, 0);
        step(I_NONE,              C_NONE, 2'd0, 0, 0);
        // Load-use: one-cycle stall
        step(I_LU,                C_LU,   2'd0, 0, 0);
        step(I_NONE,              C_NONE, 2'd0, 1, 0);
        // Mul/div with DONE three cycles after START
        step(I_MS,                C_MD,   2'd0, 1, 0);
        step(I_MS,                C_MD,   2'd1, 2, 0);
        step(I_MS,                C_MD,   2'd1, 3, 0);
        step(I_MS | I_MD,         C_NONE, 2'd1, 4, 0);
        step(I_NONE,              C_NONE, 2'd0, 4, 0);
        // Redirect during fetch wait, wrong-path fetch dropped later
        step(I_BR | I_IB,         C_BR,   2'd0, 4, 0);
        step(I_IB,                C_IW,   2'd0, 4, 1);
        step(I_IB,                C_IW,   2'd0, 5, 1);
        step(I_NONE,              C_PF,   2'd0, 6, 1);
        step(I_NONE,              C_NONE, 2'd0, 6, 1);
        // DONE arrives inside a DMEM freeze
        step(I_MS,                C_MD,   2'd0, 6, 1);
        step(I_MS | I_DB,         C_DM,   2'd1, 7, 1);
        step(I_MS | I_DB | I_MD,  C_DM,   2'd2, 8, 1);
        step(I_MS | I_DB,         C_DM,   2'd2, 9, 1);
        step(I_MS | I_DB,         C_DM,   2'd2, 10, 1);
        step(I_MS,                C_NONE, 2'd2, 11, 1);
        step(I_NONE,              C_NONE, 2'd0, 11, 1);
        // DMEM freeze during mul/div returns to MULDIV_WAIT
        step(I_MS,                C_MD,   2'd0, 11, 1);
        step(I_MS | I_DB,         C_DM,   2'd1, 12, 1);
        step(I_MS,                C_MD,   2'd2, 13, 1);
        step(I_MS | I_MD,         C_NONE, 2'd1, 14, 1);
        step(I_NONE,              C_NONE, 2'd0, 14, 1);
        // Redirect beats load-use; load-use with fetch wait holds IF/ID
        step(I_BR | I_LU,         C_BR,   2'd0, 14, 1);
        step(I_LU | I_IB,         C_LU,   2'd0, 14, 2);
        step(I_IB,                C_IW,   2'd0, 15, 2);
        // Redirect under mul/div freeze is ignored until DONE
        step(I_MS | I_BR,         C_MD,   2'd0, 15, 2);
        step(I_MS | I_MD | I_BR,  C_BR,   2'd1, 15, 2);
        step(I_NONE,              C_NONE, 2'd0, 15, 3);
        // DMEM dominates, then reset mid-freeze
        step(I_DB | I_BR | I_LU,  C_DM,   2'd0, 15, 3);
        step(I_RST | I_DB,        C_NONE, 2'd2, 15, 3);
        step(I_NONE,              C_NONE, 2'd0, 0, 0);
        // Pending flush does not survive reset
        step(I_BR | I_IB,         C_BR,   2'd0, 0, 0);
        step(I_RST,               C_NONE, 2'd0, 0, 1);
        step(I_NONE,              C_NONE, 2'd0, 0, 0);
        // Stall counter saturation
        for (int i = 0; i < 20; i++) begin
            step(I_IB, C_IW, 2'd0, (i > 15) ? 15 : i, 0);
        end
        step(I_NONE,              C_NONE, 2'd0, 15, 0);

        @(posedge clk);
        #1;
        bus.IMEM_BUSY = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
